// File: rtl/zap_shift_alu_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : zap_shift_alu_stage_pkg
// Brief    : Shared shift-type encodings and entry data type for the
//            shifter-to-ALU pipeline stage.
// Revision : 1.0 - initial release
// ============================================================================
package zap_shift_alu_stage_pkg;

    // Shift-type encodings, identical to those used by the barrel shifter.
    localparam logic [7:0] LSL  = 8'd0;
    localparam logic [7:0] LSR  = 8'd1;
    localparam logic [7:0] ASR  = 8'd2;
    localparam logic [7:0] ROR  = 8'd3;
    localparam logic [7:0] RORI = 8'd4;

    localparam int DATA_W = 32;

    // Resolved operand and carry; the destination index is appended by the
    // stage because its width is a stage parameter.
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              carry;
    } stage_data_t;

endpackage
`default_nettype wire

// File: rtl/zap_shift_carry_resolve.sv
`default_nettype none
// ============================================================================
// Module   : zap_shift_carry_resolve
// Brief    : Combinational resolution of the ARM shifter carry-out cases the
//            barrel shifter leaves open (zero-amount preserve, ROR, RRX).
// Revision : 1.0 - initial release
// ============================================================================
module zap_shift_carry_resolve
    import zap_shift_alu_stage_pkg::*;
#(
    parameter int SHIFT_OPS = 5
) (
    input  logic [31:0]                  result_in,
    input  logic                         carry_in,
    input  logic                         rrx,
    input  logic [7:0]                   amount,
    input  logic [$clog2(SHIFT_OPS)-1:0] shift_type,
    input  logic                         cpsr_c,
    output stage_data_t                  resolved
);

    logic is_ror;
    logic is_rori;

    assign is_ror  = (8'(shift_type) == ROR);
    assign is_rori = (8'(shift_type) == RORI);

    // Priority: RRX, then rotate carry, then zero-amount carry preserve.
    always_comb begin
        resolved.result = result_in;
        resolved.carry  = carry_in;
        if (rrx) begin
            resolved.result = {cpsr_c, result_in[31:1]};
            resolved.carry  = result_in[0];
        end else if ((is_ror || is_rori) && (amount[4:0] != 5'd0)) begin
            resolved.carry  = result_in[31];
        end else if (is_ror && (amount != 8'd0)) begin
            // Multiple of 32: value unchanged, carry is the top bit.
            resolved.carry  = result_in[31];
        end else if ((amount == 8'd0) && !is_ror) begin
            resolved.carry  = cpsr_c;
        end
    end

endmodule
`default_nettype wire

// File: rtl/zap_shift_alu_stage.sv
`default_nettype none
// ============================================================================
// Module   : zap_shift_alu_stage
// Brief    : Registered shifter-to-ALU stage with a 2-entry skid buffer,
//            carry resolution at accept, and pipeline flush.
//            Optional macro ZAP_SHIFT_ALU_STAGE_PERF_EN adds a saturating
//            stall counter and a flush-drop pulse.
// Revision : 1.0 - initial release
// ============================================================================
module zap_shift_alu_stage
    import zap_shift_alu_stage_pkg::*;
#(
    parameter int SHIFT_OPS = 5,
    parameter int DEST_W    = 6
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_clear,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [31:0]                  i_result,
    input  logic                         i_carry,
    input  logic                         i_rrx,
    input  logic [7:0]                   i_amount,
    input  logic [$clog2(SHIFT_OPS)-1:0] i_shift_type,
    input  logic [DEST_W-1:0]            i_dest,
    input  logic                         i_cpsr_c,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [31:0]                  o_result,
    output logic                         o_carry,
    output logic [DEST_W-1:0]            o_dest
`ifdef ZAP_SHIFT_ALU_STAGE_PERF_EN
    ,
    output logic [31:0]                  o_stall_cnt,
    output logic                         o_flush_drop
`endif
);

    typedef struct packed {
        stage_data_t       data;
        logic [DEST_W-1:0] dest;
    } entry_t;

    stage_data_t resolved;
    entry_t      new_entry;
    entry_t      main_entry;
    entry_t      skid_entry;
    logic        main_valid;
    logic        skid_valid;
    logic        push;
    logic        pop;

    zap_shift_carry_resolve #(
        .SHIFT_OPS (SHIFT_OPS)
    ) u_resolve (
        .result_in  (i_result),
        .carry_in   (i_carry),
        .rrx        (i_rrx),
        .amount     (i_amount),
        .shift_type (i_shift_type),
        .cpsr_c     (i_cpsr_c),
        .resolved   (resolved)
    );

    assign new_entry = '{data: resolved, dest: i_dest};

    // Ready depends only on registered skid state, so no i_ready-to-o_ready path.
    assign o_ready = !skid_valid;
    assign push    = i_valid && !skid_valid;
    assign pop     = main_valid && i_ready;

    // Skid buffer: main drives the outputs, skid absorbs one push under stall.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_entry <= '0;
            skid_entry <= '0;
        end else if (i_clear) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (pop) begin
                main_entry <= skid_entry;
                skid_valid <= 1'b0;
            end
        end else if (push) begin
            if (!main_valid || pop) begin
                main_entry <= new_entry;
                main_valid <= 1'b1;
            end else begin
                skid_entry <= new_entry;
                skid_valid <= 1'b1;
            end
        end else if (pop) begin
            main_valid <= 1'b0;
        end
    end

    assign o_valid  = main_valid;
    assign o_result = main_entry.data.result;
    assign o_carry  = main_entry.data.carry;
    assign o_dest   = main_entry.dest;

`ifdef ZAP_SHIFT_ALU_STAGE_PERF_EN
    // Stall counter saturates; flush does not clear it. Drop pulse is one cycle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_stall_cnt  <= '0;
            o_flush_drop <= 1'b0;
        end else begin
            if (i_valid && !o_ready && (o_stall_cnt != 32'hFFFF_FFFF)) begin
                o_stall_cnt <= o_stall_cnt + 32'd1;
            end
            o_flush_drop <= i_clear && (main_valid || skid_valid);
        end
    end
`endif

endmodule
`default_nettype wire
